// File: rtl/drowsy_pkg.sv
// Shared constants, types and FSM encoding for the drowsiness-detector front end.
package drowsy_pkg;

  localparam int DW      = 10;    // sample width
  localparam int N_FEAT  = 30;    // window length, matches detector input depth
  localparam int STRIDE  = 10;    // fresh samples between windows
  localparam int SAT_MAX = 1000;  // sample clamp ceiling

  typedef logic [DW-1:0] feat_t;
  typedef feat_t feat_vec_t [N_FEAT];

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    SLIDE     = 2'd3
  } fwb_state_e;

endpackage

// File: rtl/feature_shift_reg.sv
// N_FEAT x DW shift register: new sample enters at the top (newest), entry 0 is oldest.
module feature_shift_reg #(
  parameter int DW     = drowsy_pkg::DW,
  parameter int N_FEAT = drowsy_pkg::N_FEAT
) (
  input  logic                         Clock,
  input  logic                         Rst,
  input  logic                         clr,
  input  logic                         shift,
  input  logic [DW-1:0]                din,
  output logic [N_FEAT-1:0][DW-1:0]    q
);

  // Clear beats shift so a flushed cycle never captures the sample.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      for (int i = 0; i < N_FEAT-1; i++) q[i] <= q[i+1];
      q[N_FEAT-1] <= din;
    end
  end

endmodule

// File: rtl/feature_window_buffer.sv
// Sliding-window feeder: gathers serial samples, issues a window with a Start pulse,
// holds it until the detector reports done, then slides by STRIDE fresh samples.
module feature_window_buffer #(
  parameter int DW      = drowsy_pkg::DW,
  parameter int N_FEAT  = drowsy_pkg::N_FEAT,
  parameter int STRIDE  = drowsy_pkg::STRIDE,
  parameter int SAT_MAX = drowsy_pkg::SAT_MAX
) (
  input  logic                       Clock,
  input  logic                       Rst,
  input  logic                       flush,
  input  logic                       sample_valid,
  input  logic [DW-1:0]              sample_data,
  output logic                       sample_ready,
  input  logic                       det_done,
  output logic                       Start,
  output logic [N_FEAT-1:0][DW-1:0]  win_out,
  output logic                       busy,
  output logic [1:0]                 state,
  output logic [15:0]                win_count
);
  import drowsy_pkg::*;

  localparam int FW = $clog2(N_FEAT+1);
  localparam int SW = $clog2(STRIDE+1);
  localparam logic [FW-1:0] FILL_LAST   = FW'(N_FEAT-1);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE-1);
  localparam logic [DW-1:0] SAT_V       = DW'(SAT_MAX);

  fwb_state_e     st, st_nxt;
  logic [FW-1:0]  fill_cnt;
  logic [SW-1:0]  stride_cnt;
  logic           accept;
  logic [DW-1:0]  sat_data;

  assign sat_data = (sample_data > SAT_V) ? SAT_V : sample_data;
  assign state    = st;

  // State register.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) st <= FILL;
    else      st <= st_nxt;
  end

  // Handshake decode and next state; flush overrides everything and kills Start.
  always_comb begin
    st_nxt       = st;
    sample_ready = 1'b0;
    Start        = 1'b0;
    busy         = (st == ISSUE) || (st == WAIT_DONE);
    case (st)
      FILL:      sample_ready = 1'b1;
      ISSUE:     begin Start = 1'b1; st_nxt = WAIT_DONE; end
      WAIT_DONE: if (det_done) st_nxt = SLIDE;
      SLIDE:     sample_ready = 1'b1;
      default:   st_nxt = FILL;
    endcase
    if (flush) begin
      sample_ready = 1'b0;
      Start        = 1'b0;
    end
    accept = sample_valid && sample_ready;
    if (accept && st == FILL  && fill_cnt   == FILL_LAST)   st_nxt = ISSUE;
    if (accept && st == SLIDE && stride_cnt == STRIDE_LAST) st_nxt = ISSUE;
    if (flush) st_nxt = FILL;
  end

  // Fill/stride counters; fill_cnt parks at N_FEAT once the first window is out.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      fill_cnt   <= '0;
      stride_cnt <= '0;
    end else if (flush) begin
      fill_cnt   <= '0;
      stride_cnt <= '0;
    end else begin
      if (st == FILL && accept) fill_cnt <= fill_cnt + 1'b1;
      if (st == ISSUE)                stride_cnt <= '0;
      else if (st == SLIDE && accept) stride_cnt <= stride_cnt + 1'b1;
    end
  end

  // Issued-window counter survives flush and wraps naturally.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst)       win_count <= '0;
    else if (Start) win_count <= win_count + 16'd1;
  end

  feature_shift_reg #(.DW(DW), .N_FEAT(N_FEAT)) u_win (
    .Clock (Clock),
    .Rst   (Rst),
    .clr   (flush),
    .shift (accept),
    .din   (sat_data),
    .q     (win_out)
  );

endmodule

// File: tb/tb_feature_window_buffer.sv
// Bench for feature_window_buffer: directed scenarios plus random traffic against a window model.
module tb_feature_window_buffer;
  localparam int DW = 10;
  localparam int N  = 30;
  localparam int ST = 10;

  logic               Clock = 1'b0;
  logic               Rst;
  logic               flush = 1'b0;
  logic               sample_valid = 1'b0;
  logic [DW-1:0]      sample_data = '0;
  logic               sample_ready;
  logic               det_done = 1'b0;
  logic               Start;
  logic [N-1:0][DW-1:0] win_out;
  logic               busy;
  logic [1:0]         state;
  logic [15:0]        win_count;

  int errors = 0;
  int checks = 0;
  logic force_flag = 1'b0;

  feature_window_buffer dut (
    .Clock(Clock), .Rst(Rst), .flush(flush), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ready(sample_ready), .det_done(det_done),
    .Start(Start), .win_out(win_out), .busy(busy), .state(state), .win_count(win_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the window as a list of clamped samples plus "what is the buffer doing" phase.
  // phase 0 gathering first window, 1 presenting, 2 waiting for detector, 3 gathering stride.
  int m_win [N];
  int m_phase = 0;
  int m_filled = 0;
  int m_slid = 0;
  int m_count = 0;

  function automatic int clamp(input int v);
    return (v > 1000) ? 1000 : v;
  endfunction

  always @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < N; i++) m_win[i] <= 0;
      m_phase <= 0; m_filled <= 0; m_slid <= 0; m_count <= 0;
    end else begin
      if (flush) begin
        for (int i = 0; i < N; i++) m_win[i] <= 0;
        m_phase <= 0; m_filled <= 0; m_slid <= 0;
      end else begin
        case (m_phase)
          0: if (sample_valid) begin
               for (int i = 0; i < N-1; i++) m_win[i] <= m_win[i+1];
               m_win[N-1] <= clamp(int'(sample_data));
               m_filled <= m_filled + 1;
               if (m_filled + 1 == N) m_phase <= 1;
             end
          1: begin m_count <= (m_count + 1) % 65536; m_slid <= 0; m_phase <= 2; end
          2: if (det_done) m_phase <= 3;
          default: if (sample_valid) begin
               for (int i = 0; i < N-1; i++) m_win[i] <= m_win[i+1];
               m_win[N-1] <= clamp(int'(sample_data));
               m_slid <= m_slid + 1;
               if (m_slid + 1 == ST) m_phase <= 1;
             end
        endcase
      end
      if (force_flag) m_count <= 65535;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge Clock) begin
    logic [N-1:0][DW-1:0] ev;
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_win[i][DW-1:0];
      if (bad < 0 && win_out[i] != ev[i]) bad = i;
    end
    checks++;
    if (win_out != ev) begin
      errors++;
      $display("FAIL win_out[%0d]: got %0d expected %0d at %0t", bad, win_out[bad], ev[bad], $time);
    end
    chk("state", int'(state), m_phase);
    chk("sample_ready", int'(sample_ready), int'((m_phase == 0 || m_phase == 3) && !flush));
    chk("Start", int'(Start), int'(m_phase == 1 && !flush));
    chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
    if (!force_flag) chk("win_count", int'(win_count), m_count);
  end

  task automatic step(input logic v, input int d, input logic dn, input logic fl);
    sample_valid = v; sample_data = DW'(d); det_done = dn; flush = fl;
    @(posedge Clock); #1;
  endtask

  initial begin
    Rst = 1'b0;
    #1;
    repeat (3) @(posedge Clock);
    #1 Rst = 1'b1;
    step(0, 0, 0, 0);

    // Reset mid-fill.
    for (int i = 0; i < 5; i++) step(1, 500 + i, 0, 0);
    Rst = 1'b0;
    #100;
    chk("rst_win_zero", int'(win_out != '0), 0);
    chk("rst_state", int'(state), 0);
    Rst = 1'b1;
    step(0, 0, 0, 0);
    chk("rst_ready", int'(sample_ready), 1);
    chk("rst_count", int'(win_count), 0);

    // First window 1..30.
    for (int i = 1; i <= N; i++) step(1, i, 0, 0);
    chk("fill_start", int'(Start), 1);
    chk("fill_old", int'(win_out[0]), 1);
    chk("fill_new", int'(win_out[N-1]), 30);
    step(0, 0, 0, 0);
    chk("fill_count", int'(win_count), 1);

    // Hold without done, then slide by 31..40.
    repeat (50) step(1, 999, 0, 0);
    chk("hold_ready", int'(sample_ready), 0);
    chk("hold_old", int'(win_out[0]), 1);
    step(0, 0, 1, 0);
    for (int i = 31; i <= 40; i++) step(1, i, 0, 0);
    chk("slide_start", int'(Start), 1);
    chk("slide_old", int'(win_out[0]), 11);
    chk("slide_new", int'(win_out[N-1]), 40);
    step(0, 0, 0, 0);

    // Saturation.
    step(0, 0, 1, 0);
    step(1, 1023, 0, 0);
    chk("sat_1023", int'(win_out[N-1]), 1000);
    step(1, 999, 0, 0);
    chk("sat_keep", int'(win_out[N-2]), 1000);
    chk("sat_999", int'(win_out[N-1]), 999);
    for (int i = 0; i < ST-2; i++) step(1, 7, 0, 0);
    chk("sat_start", int'(Start), 1);
    step(0, 0, 0, 0);

    // Flush during wait abandons window; flush in fill drops sample.
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 100 + i, 0, 0);
    step(1, 77, 0, 1);
    chk("flush_clear", int'(win_out != '0), 0);
    chk("flush_count_kept", int'(win_count), 3);
    // Done held high across fill and issue must not skip the wait.
    for (int i = 0; i < N-1; i++) step(1, 200 + i, 1, 0);
    chk("flush_no_early", int'(Start), 0);
    step(1, 229, 1, 0);
    chk("flush_start", int'(Start), 1);
    chk("flush_old", int'(win_out[0]), 200);
    step(0, 0, 1, 0);
    chk("spur_wait", int'(state), 2);
    step(0, 0, 1, 0);
    chk("spur_slide", int'(state), 3);

    // Counter wrap.
    for (int i = 0; i < ST; i++) step(1, i, 0, 0);
    step(0, 0, 0, 0);
    force dut.win_count = 16'hFFFF;
    force_flag = 1'b1;
    #1 release dut.win_count;
    step(0, 0, 1, 0);
    force_flag = 1'b0;
    chk("wrap_pre", int'(win_count), 65535);
    for (int i = 0; i < ST; i++) step(1, i, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_zero", int'(win_count), 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 1023)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
